// File: rtl/dmem_access_ctrl_if.sv
// Purpose: bundle of EX/MEM data-request signals and the RAM port for the memory-stage responder.
// Latency: none (wires only).
// Backpressure: requests are held by the requester until dhit; RAM stalls the access with ramwait.
//
// Signal summary
//   request side : dmemREN, dmemWEN, dmemaddr[31:0], dmemstore[31:0], datomic, halt
//   response side: dhit, dmemload[31:0], halted, timeout
//   RAM side     : ramREN, ramWEN, ramaddr[31:0], ramstore[31:0]  (to RAM)
//                  ramload[31:0], ramwait                         (from RAM)
// Modports
//   slave  : the access controller (answers requests, drives the RAM port)
//   master : the surrounding pipeline latch plus RAM model
interface dmem_access_ctrl_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        datomic;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        halted;
    logic        timeout;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramwait;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, datomic, halt,
        input  ramload, ramwait,
        output dhit, dmemload, halted, timeout,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, datomic, halt,
        output ramload, ramwait,
        input  dhit, dmemload, halted, timeout,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Purpose: memory-stage data-access responder; one access at a time against the RAM port.
// Latency: request sampled at edge N, RAM strobe N..N+1, dhit in the following cycle (+1 per ramwait cycle).
// Backpressure: requester holds REN/WEN until dhit; ramwait stretches the access, never aborts it.
//
// Ports
//   CLK, RST  : clock (rising edge), asynchronous active-high reset
//   bus.slave : request/response and RAM signals, see dmem_access_ctrl_if
// Parameters
//   WAIT_MAX  : number of RAM wait cycles within one access that raises the sticky timeout flag
// Build option
//   DMEM_LLSC_EN : when defined, adds a single LL/SC link (valid bit + word address).
//                  When undefined, datomic is ignored and SC behaves as a plain write.
module dmem_access_ctrl #(
    parameter int WAIT_MAX = 64
) (
    input  logic              CLK,
    input  logic              RST,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [16:0] WAIT_LIM = 17'(WAIT_MAX);

    state_t      state;
    state_t      stateNext;

    logic        req;
    logic        scFail;

    // Registered copy of the request; the live request inputs are not looked
    // at again until the FSM is back in IDLE.
    logic [29:0] addrWord;
    logic [31:0] dataReg;
    logic        isWrite;

    logic [31:0] loadReg;
    logic [15:0] waitCnt;
    logic [16:0] waitNext;
    logic        timeoutReg;
    logic        haltedReg;

    logic        dhitDec;
    logic        ramRenDec;
    logic        ramWenDec;

    // Write wins when both enables are set.
    assign req      = bus.dmemREN | bus.dmemWEN;
    assign waitNext = {1'b0, waitCnt} + 17'd1;

`ifdef DMEM_LLSC_EN
    logic        isAtomic;
    logic        linkVld;
    logic [29:0] linkWord;

    // An SC that does not hit the live link never touches the RAM.
    assign scFail = bus.dmemWEN & bus.datomic
                  & ~(linkVld & (linkWord == bus.dmemaddr[31:2]));

    logic        unusedBits;
    assign unusedBits = ^bus.dmemaddr[1:0];
`else
    assign scFail = 1'b0;

    logic        unusedBits;
    assign unusedBits = ^{bus.dmemaddr[1:0], bus.datomic};
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // DONE always returns to IDLE, so a request still held during the dhit
    // cycle cannot be re-issued before the pipeline latch has advanced.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req) begin
                    stateNext = scFail ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.ramwait) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from state and registered type only, so a reset
    // (which clears state asynchronously) drops the strobes at once.
    // ------------------------------------------------------------------
    always_comb begin
        dhitDec   = 1'b0;
        ramRenDec = 1'b0;
        ramWenDec = 1'b0;
        case (state)
            ACCESS: begin
                ramRenDec = ~isWrite;
                ramWenDec = isWrite;
            end
            DONE: begin
                dhitDec = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, load data, wait counter, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addrWord   <= '0;
            dataReg    <= '0;
            isWrite    <= 1'b0;
            loadReg    <= '0;
            waitCnt    <= '0;
            timeoutReg <= 1'b0;
            haltedReg  <= 1'b0;
`ifdef DMEM_LLSC_EN
            isAtomic   <= 1'b0;
            linkVld    <= 1'b0;
            linkWord   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addrWord <= bus.dmemaddr[31:2];
                        dataReg  <= bus.dmemstore;
                        isWrite  <= bus.dmemWEN;
                        waitCnt  <= '0;
`ifdef DMEM_LLSC_EN
                        isAtomic <= bus.datomic;
                        if (scFail) begin
                            loadReg <= 32'd0;
                        end
`endif
                    end else if (bus.halt) begin
                        // Only an idle stage with nothing requested counts as drained.
                        haltedReg <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (bus.ramwait) begin
                        // Saturate rather than wrap so a stuck RAM keeps timeout asserted.
                        if (waitCnt != 16'hFFFF) begin
                            waitCnt <= waitNext[15:0];
                        end
                        if (waitNext >= WAIT_LIM) begin
                            timeoutReg <= 1'b1;
                        end
                    end else begin
`ifdef DMEM_LLSC_EN
                        if (!isWrite) begin
                            loadReg <= bus.ramload;
                            if (isAtomic) begin
                                linkVld  <= 1'b1;
                                linkWord <= addrWord;
                            end
                        end else if (isAtomic) begin
                            // Only a successful SC reaches ACCESS; report success and consume the link.
                            loadReg <= 32'd1;
                            linkVld <= 1'b0;
                        end else if (linkWord == addrWord) begin
                            // A plain store to the linked word breaks the reservation.
                            linkVld <= 1'b0;
                        end
`else
                        if (!isWrite) begin
                            loadReg <= bus.ramload;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dhit     = dhitDec;
    assign bus.ramREN   = ramRenDec;
    assign bus.ramWEN   = ramWenDec;
    assign bus.ramaddr  = {addrWord, 2'b00};
    assign bus.ramstore = dataReg;
    assign bus.dmemload = loadReg;
    assign bus.halted   = haltedReg;
    assign bus.timeout  = timeoutReg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Purpose: self-checking bench for dmem_access_ctrl (directed table, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: the bench acts as a requester holding REN/WEN until dhit and as a RAM with programmable wait.
module tb_dmem_access_ctrl;

    localparam int WMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.WAIT_MAX(WMAX)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Initial RAM contents: word 0x104 reads as 0xDEADBEEF.
    function automatic logic [31:0] initWord(input logic [29:0] wa);
        return 32'hDEAD_BEEF ^ {wa, 2'b00} ^ 32'h0000_0104;
    endfunction

    // ------------------------------------------------------------------
    // RAM model: answers strobes after waitCfg wait cycles
    // ------------------------------------------------------------------
    logic [31:0] ram [bit [29:0]];
    int waitCfg  = 0;
    int waitLeft = 0;
    bit inAcc    = 1'b0;

    always @(negedge clk) begin
        if (bus.ramREN || bus.ramWEN) begin
            if (!inAcc) begin
                inAcc    = 1'b1;
                waitLeft = waitCfg;
            end
            if (waitLeft > 0) begin
                bus.ramwait = 1'b1;
                bus.ramload = 32'hBAD0_BAD0;
                waitLeft--;
            end else begin
                bus.ramwait = 1'b0;
                bus.ramload = ram.exists(bus.ramaddr[31:2]) ? ram[bus.ramaddr[31:2]]
                                                              : initWord(bus.ramaddr[31:2]);
                if (bus.ramWEN) ram[bus.ramaddr[31:2]] = bus.ramstore;
            end
        end else begin
            inAcc       = 1'b0;
            bus.ramwait = 1'b0;
            bus.ramload = 32'hBAD0_BAD0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: transaction-level rules
    // ------------------------------------------------------------------
    logic [31:0] mdlMem [bit [29:0]];
    logic [31:0] mdlLoad    = '0;
    bit          mdlTimeout = 1'b0;
    bit          linkVld    = 1'b0;
    bit   [29:0] linkWa     = '0;

    task automatic predict(input bit ren, input bit wen, input bit at,
                           input logic [31:0] addr, input logic [31:0] data, input int waits,
                           output int lat, output logic [31:0] ld, output int nRd, output int nWr);
        bit [29:0] wa = addr[31:2];
        bit touches = 1'b1;
        lat = waits + 2;
        nRd = 0;
        nWr = 0;
        if (wen) begin
`ifdef DMEM_LLSC_EN
            if (at && !(linkVld && linkWa == wa)) begin
                mdlLoad = 32'd0;
                lat     = 1;
                touches = 1'b0;
            end else begin
                mdlMem[wa] = data;
                nWr        = waits + 1;
                if (at) mdlLoad = 32'd1;
                if (linkWa == wa) linkVld = 1'b0;
            end
`else
            mdlMem[wa] = data;
            nWr        = waits + 1;
`endif
        end else if (ren) begin
            mdlLoad = mdlMem.exists(wa) ? mdlMem[wa] : initWord(wa);
            nRd     = waits + 1;
`ifdef DMEM_LLSC_EN
            if (at) begin
                linkVld = 1'b1;
                linkWa  = wa;
            end
`endif
        end
        if (touches && waits >= WMAX) mdlTimeout = 1'b1;
        ld = mdlLoad;
    endtask

    // ------------------------------------------------------------------
    // One request held until dhit; called right after a negedge.
    // ------------------------------------------------------------------
    int lastToCyc   = 0;
    bit lastHaltSeen = 1'b0;
    bit lastH1       = 1'b0;

    task automatic doReq(input string nm, input bit ren, input bit wen, input bit at,
                         input logic [31:0] addr, input logic [31:0] data, input int waits,
                         input int expLat, input logic [31:0] expLoad,
                         input int expRd, input int expWr, input bit wiggle);
        int lat = 0;
        int nRd = 0;
        int nWr = 0;
        bit seen  = 1'b0;
        bit busOk = 1'b1;
        bit quiet = 1'b1;
        logic [31:0] ld = '0;
        lastToCyc    = 0;
        lastHaltSeen = 1'b0;
        waitCfg       = waits;
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.datomic   = at;
        bus.dmemaddr  = addr;
        bus.dmemstore = data;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.ramREN) nRd++;
            if (bus.ramWEN) nWr++;
            if ((bus.ramREN || bus.ramWEN) &&
                (bus.ramaddr !== {addr[31:2], 2'b00} || (bus.ramWEN && bus.ramstore !== data)))
                busOk = 1'b0;
            if (bus.timeout && lastToCyc == 0) lastToCyc = c;
            if (bus.halted) lastHaltSeen = 1'b1;
            if (bus.dhit) begin
                seen = 1'b1;
                lat  = c;
                ld   = bus.dmemload;
            end else if (wiggle) begin
                bus.dmemaddr  = $urandom;
                bus.dmemstore = $urandom;
            end
        end
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
        chk({nm, " dhit seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(expLat));
        chk({nm, " dmemload"}, ld, expLoad);
        chk({nm, " ramREN cycles"}, 32'(nRd), 32'(expRd));
        chk({nm, " ramWEN cycles"}, 32'(nWr), 32'(expWr));
        chk({nm, " ramaddr/ramstore"}, 32'(busOk), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.dhit || bus.ramREN || bus.ramWEN) quiet = 1'b0;
            if (k == 0) lastH1 = bus.halted;
        end
        chk({nm, " quiet after dhit"}, 32'(quiet), 32'd1);
    endtask

    typedef struct {
        bit          ren;
        bit          wen;
        bit          at;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        int          lat;
        logic [31:0] load;
        int          nRd;
        int          nWr;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pLat;
        int          pRd;
        int          pWr;
        logic [31:0] pLd;
        bit          hit;

        // {ren, wen, at, addr, data, waits, lat, load, nRd, nWr}
        tbl.push_back('{1, 0, 0, 32'h104, 32'h0,        0, 2, 32'hDEAD_BEEF, 1, 0});
        tbl.push_back('{1, 1, 0, 32'h200, 32'h1234_5678, 3, 5, 32'hDEAD_BEEF, 0, 4});
        tbl.push_back('{1, 0, 0, 32'h200, 32'h0,        1, 3, 32'h1234_5678, 2, 0});
        tbl.push_back('{1, 0, 0, 32'h203, 32'h0,        0, 2, 32'h1234_5678, 1, 0});
        tbl.push_back('{0, 1, 0, 32'h104, 32'hCAFE_F00D, 0, 2, 32'h1234_5678, 0, 1});
        tbl.push_back('{1, 0, 0, 32'h107, 32'h0,        2, 4, 32'hCAFE_F00D, 3, 0});
`ifdef DMEM_LLSC_EN
        tbl.push_back('{1, 0, 1, 32'h300, 32'h0,        0, 2, 32'hDEAD_BCEB, 1, 0});
        tbl.push_back('{0, 1, 1, 32'h300, 32'h55,       1, 3, 32'h1,         0, 2});
        tbl.push_back('{0, 1, 1, 32'h300, 32'h66,       0, 1, 32'h0,         0, 0});
        tbl.push_back('{1, 0, 0, 32'h300, 32'h0,        0, 2, 32'h55,        1, 0});
        tbl.push_back('{1, 0, 1, 32'h304, 32'h0,        0, 2, 32'hDEAD_BCEF, 1, 0});
        tbl.push_back('{0, 1, 0, 32'h304, 32'h77,       0, 2, 32'hDEAD_BCEF, 0, 1});
        tbl.push_back('{0, 1, 1, 32'h304, 32'h88,       0, 1, 32'h0,         0, 0});
`else
        tbl.push_back('{0, 1, 1, 32'h300, 32'h66,       1, 3, 32'hCAFE_F00D, 0, 2});
        tbl.push_back('{1, 0, 0, 32'h300, 32'h0,        0, 2, 32'h66,        1, 0});
        tbl.push_back('{1, 0, 1, 32'h304, 32'h0,        0, 2, 32'hDEAD_BCEF, 1, 0});
`endif

        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.datomic   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset dhit", 32'(bus.dhit), 32'd0);
        chk("reset ramREN", 32'(bus.ramREN), 32'd0);
        chk("reset ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("reset halted", 32'(bus.halted), 32'd0);
        chk("reset timeout", 32'(bus.timeout), 32'd0);
        chk("reset dmemload", bus.dmemload, 32'd0);
        chk("reset ramaddr", bus.ramaddr, 32'd0);
        chk("reset ramstore", bus.ramstore, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            predict(tbl[i].ren, tbl[i].wen, tbl[i].at, tbl[i].addr, tbl[i].data, tbl[i].waits,
                    pLat, pLd, pRd, pWr);
            doReq($sformatf("vec%0d", i), tbl[i].ren, tbl[i].wen, tbl[i].at, tbl[i].addr,
                  tbl[i].data, tbl[i].waits, tbl[i].lat, tbl[i].load, tbl[i].nRd, tbl[i].nWr, 1'b0);
        end
        chk("timeout still clear", 32'(bus.timeout), 32'd0);

        // Timeout: 10 wait cycles with WAIT_MAX=4
        predict(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 10, pLat, pLd, pRd, pWr);
        doReq("timeout rd", 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 10, 12, 32'hCAFE_F00D, 11, 0, 1'b1);
        chk("timeout first cycle", 32'(lastToCyc), 32'd5);
        chk("timeout sticky", 32'(bus.timeout), 32'd1);

        // Halt while a read is pending
        bus.halt = 1'b1;
        predict(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 2, pLat, pLd, pRd, pWr);
        doReq("halt rd", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 2, 4, 32'h1234_5678, 3, 0, 1'b0);
        chk("halted before dhit", 32'(lastHaltSeen), 32'd0);
        chk("halted after DONE", 32'(lastH1), 32'd0);
        chk("halted on IDLE edge", 32'(bus.halted), 32'd1);
        bus.halt = 1'b0;
        @(negedge clk);
        chk("halted sticky", 32'(bus.halted), 32'd1);
        chk("timeout still sticky", 32'(bus.timeout), 32'd1);

        // Reset in the middle of an access
        waitCfg      = 8;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h104;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset ramREN", 32'(bus.ramREN), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async strobe drop", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        bus.dmemREN = 1'b0;
        hit = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.dhit) hit = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dhit) hit = 1'b1;
        end
        chk("no dhit after reset", 32'(hit), 32'd0);
        chk("timeout cleared", 32'(bus.timeout), 32'd0);
        chk("halted cleared", 32'(bus.halted), 32'd0);
        chk("dmemload cleared", bus.dmemload, 32'd0);
        mdlLoad    = '0;
        mdlTimeout = 1'b0;
        linkVld    = 1'b0;
        predict(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 0, pLat, pLd, pRd, pWr);
        doReq("post-reset rd", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 0, 2, 32'h1234_5678, 1, 0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            int          kind  = $urandom_range(0, 3);
            bit          ren   = (kind != 1);
            bit          wen   = (kind == 1) || (kind == 2);
            bit          at    = 1'($urandom_range(0, 1));
            logic [31:0] addr  = 32'h300 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
            logic [31:0] data  = $urandom;
            int          waits = $urandom_range(0, 5);
            bit          wig   = 1'($urandom_range(0, 1));
            predict(ren, wen, at, addr, data, waits, pLat, pLd, pRd, pWr);
            doReq($sformatf("rnd%0d", n), ren, wen, at, addr, data, waits, pLat, pLd, pRd, pWr, wig);
            chk($sformatf("rnd%0d timeout", n), 32'(bus.timeout), 32'(mdlTimeout));
        end
        chk("halted stays clear", 32'(bus.halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
